wb_line_initiator: RTL and testbench
====================================

// Module: wb_line_initiator
// PURPOSE
//  Wishbone initiator for cache line traffic: accepts a single line read/write request from
//  the cache controller and runs it as one classic Wishbone cycle on the memory bus.
//  It is the bus-master end of the interface the memory responder serves.
//  Handles ACK, and RTY with bounded retry. Returns data and status to the cache.
// PARAMETERS
//  DATA_W     128  line width in bits (one beat per line)
//  ADR_W      28   line address width (byte addr [31:4])
//  SEL_W      16   byte-select width, DATA_W/8
//  MAX_RETRY  4    RTY responses tolerated before reporting error
//  BACKOFF    2    idle cycles (CYC low) between RTY and re-issue
//  TIMEOUT    64   cycles waiting for ACK/RTY before abort (WB_TIMEOUT_EN only)
// PORTS
//  Clk        in   1       sole clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  req_valid  in   1       cache request; held with fields until req_ready
//  req_ready  out  1       high in IDLE only; request accepted when valid&ready
//  req_we     in   1       1 = line write, 0 = line read
//  req_adr    in   ADR_W   line address
//  req_sel    in   SEL_W   byte enables (writes); reads drive all-ones
//  req_wdata  in   DATA_W  write data
//  resp_valid out  1       one-cycle pulse, completion
//  resp_err   out  1       qualifies resp_valid: retries exhausted or timeout
//  resp_rdata out  DATA_W  read data, valid with resp_valid on reads
//  CYC,STB    out  1       Wishbone cycle/strobe (always driven equal)
//  WE         out  1       Wishbone write enable
//  ADR        out  ADR_W   Wishbone address
//  SEL        out  SEL_W   Wishbone byte select
//  DAT_M      out  DATA_W  Wishbone write data
//  DAT_S      in   DATA_W  Wishbone read data
//  ACK,RTY    in   1       Wishbone responses; ACK wins if both high
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1; state IDLE; counters 0. Async reset mid-cycle
//   drops CYC/STB immediately, request lost, no resp issued.
//  States: IDLE -> BUS on accept; request fields registered on acceptance.
//   BUS: CYC=STB=1, WE/ADR/SEL/DAT_M from registers, stable until exit.
//    ACK sampled high -> DONE; RTY (no ACK) -> retry_cnt++; if retry_cnt==MAX_RETRY -> DONE(err)
//    else -> WAIT.
//   WAIT: CYC=STB=0 for exactly BACKOFF cycles, then BUS.
//   DONE: resp_valid=1 one cycle; resp_rdata=DAT_S captured on ACK edge (held until next read
//    completes); resp_err per cause; next cycle IDLE, retry_cnt cleared.
//  Latency: accept at edge N -> STB high cycle N+1; ACK at edge M -> resp_valid in cycle M+1.
//   Min accept-to-resp 2 cycles. Back-to-back: new request accepted one cycle after resp.
//  CYC/STB deasserted in the cycle after ACK (no pipelined/burst cycles).
//  ACK/RTY outside BUS ignored. req_* changes while not ready ignored.
//  retry_cnt width $clog2(MAX_RETRY+1); saturates, never wraps.
// CONFIGURATION
//  WB_TIMEOUT_EN defined: cycle counter in BUS, cleared on entry; reaching TIMEOUT with no
//   ACK/RTY drops CYC/STB, goes DONE with resp_err=1, resp_rdata unchanged.
//  Undefined: no counter; BUS waits indefinitely for ACK/RTY.
// TESTING
//  Read 0x0000123, ACK after 3 cycles, DAT_S=128'hDEAD..BEEF -> resp_valid 1 cyc, rdata match, err=0
//  Write adr 0x0ABCDEF sel 16'h00F0 -> WE=1, ADR/SEL/DAT_M stable whole cycle, ACK -> resp err=0
//  RTY twice then ACK -> two 2-cycle CYC-low gaps, identical re-issue, resp err=0
//  RTY 4 times (MAX_RETRY=4) -> resp_valid with err=1, no 5th strobe
//  rst pulse while STB high -> CYC/STB 0 same cycle, req_ready=1, no resp_valid
//  WB_TIMEOUT_EN, responder silent -> STB drops after 64 cycles, resp err=1

Source files
------------

// File: rtl/wb_line_initiator.sv
// Wishbone classic initiator: runs one cache-line read/write per bus cycle, with RTY backoff and bounded retry.
// Optional macro WB_TIMEOUT_EN aborts a bus cycle that sees no ACK/RTY within TIMEOUT cycles.
module wb_line_initiator #(
    parameter int DATA_W    = 128,
    parameter int ADR_W     = 28,
    parameter int SEL_W     = DATA_W / 8,
    parameter int MAX_RETRY = 4,
    parameter int BACKOFF   = 2
`ifdef WB_TIMEOUT_EN
    ,parameter int TIMEOUT  = 64
`endif
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADR_W-1:0]  req_adr,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              CYC,
    output logic              STB,
    output logic              WE,
    output logic [ADR_W-1:0]  ADR,
    output logic [SEL_W-1:0]  SEL,
    output logic [DATA_W-1:0] DAT_M,
    input  logic [DATA_W-1:0] DAT_S,
    input  logic              ACK,
    input  logic              RTY
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam int BO_W = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam logic [BO_W-1:0] BO_LAST = BO_W'(BACKOFF - 1);
`ifdef WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                fail;
    logic                we_q;
    logic [ADR_W-1:0]    adr_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   dat_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [BO_W-1:0]     bo_cnt;
`ifdef WB_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_cnt;
`endif

    // Outputs decode straight from the state register so an async reset drops CYC/STB at once.
    assign req_ready  = (state == ST_IDLE);
    assign CYC        = (state == ST_BUS);
    assign STB        = (state == ST_BUS);
    assign resp_valid = (state == ST_DONE);
    assign resp_err   = (state == ST_DONE) && err_q;
    assign resp_rdata = rdata_q;
    assign WE         = we_q;
    assign ADR        = adr_q;
    assign SEL        = sel_q;
    assign DAT_M      = dat_q;

    always_comb begin
        next_state = state;
        fail       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) next_state = ST_BUS;
            end
            ST_BUS: begin
                if (ACK) begin
                    next_state = ST_DONE;
                end else if (RTY) begin
                    if (retry_cnt == RETRY_LAST) begin
                        next_state = ST_DONE;
                        fail       = 1'b1;
                    end else begin
                        next_state = (BACKOFF == 0) ? ST_BUS : ST_WAIT;
                    end
                end
`ifdef WB_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    next_state = ST_DONE;
                    fail       = 1'b1;
                end
`endif
            end
            ST_WAIT: begin
                if (bo_cnt == BO_LAST) next_state = ST_BUS;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Request fields are captured once at acceptance; reads always present a full byte select.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                we_q  <= req_we;
                adr_q <= req_adr;
                sel_q <= req_we ? req_sel : '1;
                dat_q <= req_wdata;
            end
            if (state == ST_BUS) err_q <= fail;
            if (state == ST_BUS && ACK && !we_q) rdata_q <= DAT_S;
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
            bo_cnt    <= '0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            if (state == ST_DONE) begin
                retry_cnt <= '0;
            end else if (state == ST_BUS && RTY && !ACK && retry_cnt != RETRY_MAX) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end
            if (state == ST_WAIT) bo_cnt <= bo_cnt + BO_W'(1);
            else                  bo_cnt <= '0;
`ifdef WB_TIMEOUT_EN
            if (state != ST_BUS || RTY) tmo_cnt <= '0;
            else                        tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
        end
    end

endmodule

// File: tb/tb_wb_line_initiator.sv
// Directed bench for wb_line_initiator: a transaction-level model queues per-cycle expectations that a compare process checks.
// Honours WB_TIMEOUT_EN the same way the design does.
module tb_wb_line_initiator;

    localparam int DATA_W    = 128;
    localparam int ADR_W     = 28;
    localparam int SEL_W     = 16;
    localparam int MAX_RETRY = 4;
    localparam int BACKOFF   = 2;
    localparam int TIMEOUT   = 64;

    logic              Clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADR_W-1:0]  req_adr = '0;
    logic [SEL_W-1:0]  req_sel = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              CYC;
    logic              STB;
    logic              WE;
    logic [ADR_W-1:0]  ADR;
    logic [SEL_W-1:0]  SEL;
    logic [DATA_W-1:0] DAT_M;
    logic [DATA_W-1:0] DAT_S = '0;
    logic              ACK = 1'b0;
    logic              RTY = 1'b0;

    wb_line_initiator dut (
        .Clk(Clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_sel(req_sel), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR), .SEL(SEL), .DAT_M(DAT_M),
        .DAT_S(DAT_S), .ACK(ACK), .RTY(RTY)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit                ready;
        bit                cyc;
        bit                resp;
        bit                err;
        bit                chk_fields;
        bit                chk_rdata;
        bit                we;
        logic [ADR_W-1:0]  adr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] dat_m;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              exp_q[$];
    int                n_cmp = 0;
    int                n_fail = 0;
    int                stb_cycles = 0;
    int                resp_count = 0;
    int                err_count = 0;
    logic              cur_we = 1'b0;
    logic [ADR_W-1:0]  cur_adr = '0;
    logic [SEL_W-1:0]  cur_sel = '0;
    logic [DATA_W-1:0] cur_dat = '0;
    logic [DATA_W-1:0] last_rdata = '0;

    task automatic check_output(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Checks every queued cycle expectation mid-cycle, away from the active edge.
    initial begin
        forever begin
            exp_t e;
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("req_ready", DATA_W'(req_ready), DATA_W'(e.ready));
                check_output("CYC", DATA_W'(CYC), DATA_W'(e.cyc));
                check_output("STB", DATA_W'(STB), DATA_W'(e.cyc));
                check_output("resp_valid", DATA_W'(resp_valid), DATA_W'(e.resp));
                check_output("resp_err", DATA_W'(resp_err), DATA_W'(e.err));
                if (e.chk_fields) begin
                    check_output("WE", DATA_W'(WE), DATA_W'(e.we));
                    check_output("ADR", DATA_W'(ADR), DATA_W'(e.adr));
                    check_output("SEL", DATA_W'(SEL), DATA_W'(e.sel));
                    check_output("DAT_M", DAT_M, e.dat_m);
                end
                if (e.chk_rdata) check_output("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    always @(negedge Clk) begin
        if (STB) stb_cycles++;
        if (resp_valid) resp_count++;
        if (resp_valid && resp_err) err_count++;
    end

    function automatic logic [DATA_W-1:0] noise();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step(input bit ready, input bit cyc, input bit resp, input bit err,
                        input bit chk_fields, input bit chk_rdata);
        exp_t e;
        e.ready = ready; e.cyc = cyc; e.resp = resp; e.err = err;
        e.chk_fields = chk_fields; e.chk_rdata = chk_rdata;
        e.we = cur_we; e.adr = cur_adr; e.sel = cur_sel; e.dat_m = cur_dat; e.rdata = last_rdata;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    // One line transaction: n_rty RTY answers then ACK, each after dly silent strobe cycles.
    task automatic apply_stimulus(input bit we, input logic [ADR_W-1:0] adr, input logic [SEL_W-1:0] sel,
                                  input logic [DATA_W-1:0] wdata, input int n_rty, input int dly,
                                  input bit silent, input bit both, input logic [DATA_W-1:0] dat_s);
        int tries;
        bit err;
        req_valid = 1'b1; req_we = we; req_adr = adr; req_sel = sel; req_wdata = wdata;
        ACK = 1'b0; RTY = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        req_valid = 1'b0; req_we = ~we; req_adr = ~adr; req_sel = ~sel; req_wdata = ~wdata;
        cur_we = we; cur_adr = adr; cur_sel = we ? sel : '1; cur_dat = wdata;
        tries = 0;
        err = 1'b0;
        forever begin
            if (silent) begin
                for (int i = 0; i < TIMEOUT; i++) begin
                    DAT_S = noise();
                    step(0, 1, 0, 0, 1, 0);
                end
                err = 1'b1;
                break;
            end
            for (int i = 0; i < dly; i++) begin
                ACK = 1'b0; RTY = 1'b0; DAT_S = noise();
                step(0, 1, 0, 0, 1, 0);
            end
            if (tries < n_rty) begin
                RTY = 1'b1; ACK = 1'b0; DAT_S = noise();
                step(0, 1, 0, 0, 1, 0);
                RTY = 1'b0;
                tries++;
                if (tries == MAX_RETRY) begin
                    err = 1'b1;
                    break;
                end
                for (int i = 0; i < BACKOFF; i++) begin
                    ACK = 1'b1;
                    step(0, 0, 0, 0, 0, 0);
                end
                ACK = 1'b0;
            end else begin
                ACK = 1'b1; RTY = both; DAT_S = dat_s;
                step(0, 1, 0, 0, 1, 0);
                if (!we) last_rdata = dat_s;
                break;
            end
        end
        ACK = 1'b0; RTY = 1'b0; DAT_S = noise();
        req_valid = 1'b1;
        step(0, 0, 1, err, 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic clear_counts();
        stb_cycles = 0;
        resp_count = 0;
        err_count  = 0;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        rst = 1'b0;
        check_output("reset req_ready", DATA_W'(req_ready), DATA_W'(1));
        check_output("reset CYC", DATA_W'(CYC), DATA_W'(0));
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 1);

        $display("[TB] read with ACK after two silent strobe cycles");
        clear_counts();
        apply_stimulus(1'b0, 28'h0000123, 16'h1234, 128'h0, 0, 2, 1'b0, 1'b0,
                       128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
        check_output("read stb cycles", DATA_W'(stb_cycles), DATA_W'(3));
        check_output("read resp count", DATA_W'(resp_count), DATA_W'(1));
        check_output("read err count", DATA_W'(err_count), DATA_W'(0));

        $display("[TB] write, byte select 00F0");
        apply_stimulus(1'b1, 28'h0ABCDEF, 16'h00F0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                       0, 1, 1'b0, 1'b0, 128'h5A5A);

        $display("[TB] two RTY then ACK");
        clear_counts();
        apply_stimulus(1'b0, 28'h0F0F0F0, 16'h0, 128'h0, 2, 0, 1'b0, 1'b0, 128'hCAFE_F00D);
        check_output("retry stb cycles", DATA_W'(stb_cycles), DATA_W'(3));
        check_output("retry err count", DATA_W'(err_count), DATA_W'(0));

        $display("[TB] RTY exhausts retries");
        clear_counts();
        apply_stimulus(1'b1, 28'h1234567, 16'hFFFF, 128'hAAAA_5555, 4, 0, 1'b0, 1'b0, 128'h0);
        check_output("exhaust stb cycles", DATA_W'(stb_cycles), DATA_W'(4));
        check_output("exhaust resp count", DATA_W'(resp_count), DATA_W'(1));
        check_output("exhaust err count", DATA_W'(err_count), DATA_W'(1));

        $display("[TB] ACK and RTY together, back-to-back read");
        apply_stimulus(1'b0, 28'h7FFFFFF, 16'h0, 128'h0, 1, 1, 1'b0, 1'b1, 128'h1357_9BDF);

`ifdef WB_TIMEOUT_EN
        $display("[TB] silent responder times out");
        clear_counts();
        apply_stimulus(1'b0, 28'h0000444, 16'h0, 128'h0, 0, 0, 1'b1, 1'b0, 128'h0);
        check_output("timeout stb cycles", DATA_W'(stb_cycles), DATA_W'(64));
        check_output("timeout err count", DATA_W'(err_count), DATA_W'(1));
`else
        $display("[TB] long wait without timeout");
        clear_counts();
        apply_stimulus(1'b0, 28'h0000444, 16'h0, 128'h0, 0, 80, 1'b0, 1'b0, 128'h2468_ACE0);
        check_output("long wait stb cycles", DATA_W'(stb_cycles), DATA_W'(81));
        check_output("long wait err count", DATA_W'(err_count), DATA_W'(0));
`endif

        $display("[TB] async reset while strobing");
        clear_counts();
        req_valid = 1'b1; req_we = 1'b0; req_adr = 28'h0000999; req_sel = '0; req_wdata = '0;
        step(1, 0, 0, 0, 0, 0);
        req_valid = 1'b0;
        cur_we = 1'b0; cur_adr = 28'h0000999; cur_sel = '1; cur_dat = '0;
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_output("rst CYC", DATA_W'(CYC), DATA_W'(0));
        check_output("rst STB", DATA_W'(STB), DATA_W'(0));
        check_output("rst req_ready", DATA_W'(req_ready), DATA_W'(1));
        check_output("rst resp_valid", DATA_W'(resp_valid), DATA_W'(0));
        @(posedge Clk);
        #1;
        rst = 1'b0;
        cur_we = 1'b0; cur_adr = '0; cur_sel = '0; cur_dat = '0; last_rdata = '0;
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 1);
        check_output("rst resp count", DATA_W'(resp_count), DATA_W'(0));

        $display("[TB] read after reset");
        apply_stimulus(1'b0, 28'h0000ABC, 16'h0, 128'h0, 0, 1, 1'b0, 1'b0, 128'h0BAD_C0DE);
        step(1, 0, 0, 0, 0, 1);
        @(negedge Clk);
        #1;
        check_output("expectations drained", DATA_W'(exp_q.size()), DATA_W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
